// File: rtl/irq_controller_if.sv
// Device-bus and CPU-side interrupt signals for the interrupt controller.
interface irq_controller_if #(
  parameter int N_SRC = 6
);
  logic [31:0]      addr;
  logic             write_enable;
  logic [31:0]      write_data;
  logic [31:0]      read_result;
  logic [N_SRC-1:0] irq_in;
  logic             cpu_ack;
  logic             cpu_irq;
  logic [2:0]       cpu_vector;

  modport master (
    output addr, write_enable, write_data, irq_in, cpu_ack,
    input  read_result, cpu_irq, cpu_vector
  );

  modport slave (
    input  addr, write_enable, write_data, irq_in, cpu_ack,
    output read_result, cpu_irq, cpu_vector
  );
endinterface

// File: rtl/irq_controller.sv
// Programmable interrupt controller: edge/level latching, masking, fixed
// priority with nesting, one vectored request to the CPU with ack and EOI.
module irq_controller #(
  parameter logic [31:0] BASE  = 32'h0000_7f20,
  parameter int          N_SRC = 6
) (
  input logic              clk,
  input logic              rst,
  irq_controller_if.slave  bus
);

  localparam logic [0:0]       IDLE = 1'b0;
  localparam logic [0:0]       REQ  = 1'b1;
  localparam logic [N_SRC-1:0] ONE  = N_SRC'(1);

  logic [0:0]       state;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] mode;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] inservice;
  logic [N_SRC-1:0] irq_q;
  logic             cpu_irq_r;
  logic [2:0]       cpu_vector_r;

  logic [31:0]      offset;
  logic [N_SRC-1:0] wdata;
  logic             wr_mask, wr_w1c, wr_eoi, wr_mode;
  logic             ack_take;
  logic [N_SRC-1:0] vec_sel;
  logic             vec_live;
  logic [N_SRC-1:0] top_isr;
  logic [N_SRC-1:0] allowed;
  logic [N_SRC-1:0] cand_set;
  logic             cand_valid;
  logic [2:0]       cand_idx;
  logic [N_SRC-1:0] edge_set;
  logic [N_SRC-1:0] edge_clr;
  logic [N_SRC-1:0] pending_next;
  logic [N_SRC-1:0] isr_next;
  logic             unused_bits;

  function automatic logic [2:0] lowest_idx(input logic [N_SRC-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign offset   = bus.addr - BASE;
  assign wdata    = bus.write_data[N_SRC-1:0];
  assign wr_mask  = bus.write_enable && (offset == 32'h00);
  assign wr_w1c   = bus.write_enable && (offset == 32'h08);
  assign wr_eoi   = bus.write_enable && (offset == 32'h0C);
  assign wr_mode  = bus.write_enable && (offset == 32'h10);
  assign ack_take = (state == REQ) && bus.cpu_ack;
  assign vec_sel  = ONE << cpu_vector_r;
  assign vec_live = |(pending & mask & vec_sel);

  // Only sources numerically below the most urgent in-service one may nest.
  assign top_isr    = inservice & (~inservice + ONE);
  assign allowed    = (inservice == '0) ? '1 : (top_isr - ONE);
  assign cand_set   = pending & mask & allowed;
  assign cand_valid = |cand_set;
  assign cand_idx   = lowest_idx(cand_set);

  // A fresh edge outranks W1C or ack clearing the same bit.
  always_comb begin
    edge_set     = bus.irq_in & ~irq_q;
    edge_clr     = (wr_w1c ? wdata : '0) | (ack_take ? vec_sel : '0);
    pending_next = (mode & (edge_set | (pending & ~edge_clr))) | (~mode & bus.irq_in);
    isr_next     = (wr_eoi ? (inservice & ~top_isr) : inservice) | (ack_take ? vec_sel : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      mask         <= '0;
      mode         <= '0;
      pending      <= '0;
      inservice    <= '0;
      irq_q        <= '0;
      cpu_irq_r    <= 1'b0;
      cpu_vector_r <= 3'd0;
    end else begin
      irq_q     <= bus.irq_in;
      pending   <= pending_next;
      inservice <= isr_next;
      if (wr_mask) mask <= wdata;
      if (wr_mode) mode <= wdata;
      case (state)
        IDLE: begin
          if (cand_valid) begin
            state        <= REQ;
            cpu_irq_r    <= 1'b1;
            cpu_vector_r <= cand_idx;
          end
        end
        REQ: begin
          if (bus.cpu_ack || !vec_live) begin
            state     <= IDLE;
            cpu_irq_r <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.read_result = 32'h0;
    case (offset)
      32'h00:  bus.read_result = 32'(mask);
      32'h04:  bus.read_result = 32'(pending);
      32'h08:  bus.read_result = 32'(inservice);
      32'h10:  bus.read_result = 32'(mode);
      32'h14:  bus.read_result = {cpu_irq_r, 28'b0, cpu_vector_r};
      default: bus.read_result = 32'h0;
    endcase
  end

  assign bus.cpu_irq    = cpu_irq_r;
  assign bus.cpu_vector = cpu_vector_r;
  assign unused_bits    = ^bus.write_data[31:N_SRC];

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: register access, edge/level requests,
// nesting, withdrawal, same-edge collisions and reset during a request.
`timescale 1ns/1ps
module tb_irq_controller;

  localparam logic [31:0] BASE = 32'h0000_7f20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] v;

  irq_controller_if #(.N_SRC(6)) bus ();

  irq_controller #(.BASE(BASE), .N_SRC(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #50 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    bus.addr         = BASE + 32'(off);
    bus.write_data   = d;
    bus.write_enable = 1'b1;
    tick(1);
    bus.write_enable = 1'b0;
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] r);
    bus.addr = BASE + 32'(off);
    #1;
    r = bus.read_result;
  endtask

  task automatic ack();
    bus.cpu_ack = 1'b1;
    tick(1);
    bus.cpu_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    for (int off = 0; off <= 8'h18; off += 4) begin
      rd(8'(off), v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_read_%0h: got %h want %h", off, v, 32'h0); end
    end
    checks++; if (bus.cpu_irq !== 1'b0) begin errors++; $display("FAIL reset_cpu_irq: got %b want 0", bus.cpu_irq); end
    wr(8'h00, 32'hFFFF_FF3F);
    wr(8'h10, 32'h0000_0001);
    rd(8'h00, v);
    checks++; if (v !== 32'h3F) begin errors++; $display("FAIL mask_readback: got %h want %h", v, 32'h3F); end
    rd(8'h10, v);
    checks++; if (v !== 32'h01) begin errors++; $display("FAIL mode_readback: got %h want %h", v, 32'h01); end
  endtask

  task automatic test_edge();
    wr(8'h00, 32'h01);
    bus.irq_in = 6'h01;
    tick(1);
    rd(8'h04, v);
    checks++; if (v !== 32'h01) begin errors++; $display("FAIL edge_pending: got %h want %h", v, 32'h01); end
    checks++; if (bus.cpu_irq !== 1'b0) begin errors++; $display("FAIL edge_irq_early: got %b want 0", bus.cpu_irq); end
    bus.irq_in = 6'h00;
    tick(1);
    checks++; if (bus.cpu_irq !== 1'b1) begin errors++; $display("FAIL edge_irq: got %b want 1", bus.cpu_irq); end
    checks++; if (bus.cpu_vector !== 3'd0) begin errors++; $display("FAIL edge_vector: got %0d want 0", bus.cpu_vector); end
    rd(8'h14, v);
    checks++; if (v !== 32'h8000_0000) begin errors++; $display("FAIL edge_status: got %h want %h", v, 32'h8000_0000); end
    ack();
    rd(8'h04, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL edge_ack_pending: got %h want %h", v, 32'h0); end
    rd(8'h08, v);
    checks++; if (v !== 32'h01) begin errors++; $display("FAIL edge_ack_isr: got %h want %h", v, 32'h01); end
    checks++; if (bus.cpu_irq !== 1'b0) begin errors++; $display("FAIL edge_ack_irq: got %b want 0", bus.cpu_irq); end
    wr(8'h0C, 32'hDEAD_BEEF);
    rd(8'h08, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL edge_eoi_isr: got %h want %h", v, 32'h0); end
  endtask

  task automatic test_level();
    wr(8'h10, 32'h00);
    wr(8'h00, 32'h06);
    bus.irq_in = 6'h06;
    tick(2);
    checks++; if (bus.cpu_irq !== 1'b1) begin errors++; $display("FAIL level_irq: got %b want 1", bus.cpu_irq); end
    checks++; if (bus.cpu_vector !== 3'd1) begin errors++; $display("FAIL level_vector: got %0d want 1", bus.cpu_vector); end
    ack();
    rd(8'h08, v);
    checks++; if (v !== 32'h02) begin errors++; $display("FAIL level_isr: got %h want %h", v, 32'h02); end
    rd(8'h04, v);
    checks++; if (v !== 32'h06) begin errors++; $display("FAIL level_pending_kept: got %h want %h", v, 32'h06); end
    tick(3);
    checks++; if (bus.cpu_irq !== 1'b0) begin errors++; $display("FAIL level_blocked: got %b want 0", bus.cpu_irq); end
    wr(8'h0C, 32'h0);
    tick(1);
    checks++; if (bus.cpu_irq !== 1'b1) begin errors++; $display("FAIL level_rereq_irq: got %b want 1", bus.cpu_irq); end
    checks++; if (bus.cpu_vector !== 3'd1) begin errors++; $display("FAIL level_rereq_vector: got %0d want 1", bus.cpu_vector); end
    bus.irq_in = 6'h00;
    ack();
    wr(8'h0C, 32'h0);
    rd(8'h08, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL level_cleanup_isr: got %h want %h", v, 32'h0); end
  endtask

  task automatic test_nesting();
    wr(8'h10, 32'h0A);
    wr(8'h00, 32'h0A);
    bus.irq_in = 6'h08;
    tick(1);
    bus.irq_in = 6'h00;
    tick(1);
    checks++; if (bus.cpu_vector !== 3'd3) begin errors++; $display("FAIL nest_vector3: got %0d want 3", bus.cpu_vector); end
    ack();
    bus.irq_in = 6'h02;
    tick(1);
    bus.irq_in = 6'h00;
    tick(1);
    checks++; if (bus.cpu_irq !== 1'b1) begin errors++; $display("FAIL nest_irq: got %b want 1", bus.cpu_irq); end
    checks++; if (bus.cpu_vector !== 3'd1) begin errors++; $display("FAIL nest_vector1: got %0d want 1", bus.cpu_vector); end
    ack();
    rd(8'h08, v);
    checks++; if (v !== 32'h0A) begin errors++; $display("FAIL nest_isr: got %h want %h", v, 32'h0A); end
    wr(8'h0C, 32'h0);
    rd(8'h08, v);
    checks++; if (v !== 32'h08) begin errors++; $display("FAIL nest_eoi: got %h want %h", v, 32'h08); end
    wr(8'h0C, 32'h0);
  endtask

  task automatic test_withdrawal();
    wr(8'h10, 32'h04);
    wr(8'h00, 32'h04);
    bus.irq_in = 6'h04;
    tick(1);
    bus.irq_in = 6'h00;
    tick(1);
    checks++; if (bus.cpu_vector !== 3'd2) begin errors++; $display("FAIL wd_vector: got %0d want 2", bus.cpu_vector); end
    wr(8'h08, 32'h04);
    tick(1);
    checks++; if (bus.cpu_irq !== 1'b0) begin errors++; $display("FAIL wd_irq_drop: got %b want 0", bus.cpu_irq); end
    ack();
    rd(8'h08, v);
    checks++; if (v !== 32'h0) begin errors++; $display("FAIL wd_isr: got %h want %h", v, 32'h0); end
    checks++; if (bus.cpu_irq !== 1'b0) begin errors++; $display("FAIL wd_irq_after_ack: got %b want 0", bus.cpu_irq); end
  endtask

  task automatic test_same_edge();
    wr(8'h10, 32'h01);
    wr(8'h00, 32'h00);
    bus.irq_in = 6'h01;
    wr(8'h08, 32'h01);
    rd(8'h04, v);
    checks++; if (v !== 32'h01) begin errors++; $display("FAIL w1c_vs_set: got %h want %h", v, 32'h01); end
    wr(8'h00, 32'h01);
    tick(1);
    checks++; if (bus.cpu_irq !== 1'b1) begin errors++; $display("FAIL ack_set_req: got %b want 1", bus.cpu_irq); end
    bus.irq_in = 6'h00;
    tick(1);
    bus.irq_in = 6'h01;
    ack();
    rd(8'h04, v);
    checks++; if (v !== 32'h01) begin errors++; $display("FAIL ack_vs_set_pending: got %h want %h", v, 32'h01); end
    rd(8'h08, v);
    checks++; if (v !== 32'h01) begin errors++; $display("FAIL ack_vs_set_isr: got %h want %h", v, 32'h01); end
    bus.irq_in = 6'h00;
    wr(8'h08, 32'h01);
    wr(8'h0C, 32'h0);
  endtask

  task automatic test_reset_in_req();
    wr(8'h00, 32'h01);
    bus.irq_in = 6'h01;
    tick(1);
    bus.irq_in = 6'h00;
    tick(1);
    checks++; if (bus.cpu_irq !== 1'b1) begin errors++; $display("FAIL rstreq_irq: got %b want 1", bus.cpu_irq); end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++; if (bus.cpu_irq !== 1'b0) begin errors++; $display("FAIL rstreq_irq_drop: got %b want 0", bus.cpu_irq); end
    for (int off = 0; off <= 8'h14; off += 4) begin
      rd(8'(off), v);
      checks++; if (v !== 32'h0) begin errors++; $display("FAIL rstreq_read_%0h: got %h want %h", off, v, 32'h0); end
    end
  endtask

  initial begin
    bus.addr         = BASE;
    bus.write_enable = 1'b0;
    bus.write_data   = 32'h0;
    bus.irq_in       = 6'h00;
    bus.cpu_ack      = 1'b0;
    test_reset();
    test_edge();
    test_level();
    test_nesting();
    test_withdrawal();
    test_same_edge();
    test_reset_in_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_controller.md
# irq_controller

Memory-mapped programmable interrupt controller between the peripheral `irq` outputs (timers and other bus devices) and the CPU's external interrupt input. It latches up to N_SRC request lines in edge or level mode, masks them, and resolves fixed priority with nesting. It presents one request plus vector to the CPU with an ack handshake and tracks in-service sources until software writes EOI. It occupies a word-addressed window on the same device bus as the timers.

## Interface
- BASE, 32'h00007f20, byte address of register window (6 words, offsets 0x00-0x14)
- N_SRC, 6, number of interrupt sources, legal range 1..8; source 0 has highest priority
- clk  in  1  clock, all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- addr  in  32  bus byte address
- write_enable  in  1  bus write strobe, one cycle per write
- write_data  in  32  bus write data
- read_result  out  32  combinational read of addressed register; 0 outside the window
- irq_in  in  N_SRC  device interrupt lines, synchronous to clk
- cpu_ack  in  1  one-cycle pulse: CPU has taken the request shown on cpu_vector
- cpu_irq  out  1  registered interrupt request to CPU
- cpu_vector  out  3  registered source index of the current request

## Operation
- Offset = addr - BASE; write effective only when write_enable=1 and offset is 0x00, 0x08 (W1C), 0x0C or 0x10; other writes ignored.
- 0x00 MASK (RW): bit i=1 enables source i. Reset 0.
- 0x04 PENDING (R): latched requests.
- 0x08 PENDING W1C: writing 1 to bit i clears edge-mode pending i. No effect on level-mode bits.
- 0x0C EOI (W, data ignored): clears highest-priority (lowest index) set INSERVICE bit. No-op if INSERVICE=0.
- 0x10 MODE (RW): bit i=1 edge, 0 level. Reset 0.
- 0x14 STATUS (R): {cpu_irq, 28'b0, cpu_vector}. INSERVICE is read at 0x08.
- Unused upper bits read 0; all register fields are N_SRC bits wide.
- Edge mode: pending[i] set when irq_in[i]=1 and irq_q[i]=0 (irq_q = irq_in registered); held until W1C or ack.
- Level mode: pending[i] <= irq_in[i] every cycle; ack does not clear it.
- Candidate = lowest index i with pending[i] & MASK[i] and i strictly above (lower index than) the highest-priority INSERVICE bit; none if no such i.
- FSM IDLE: if candidate exists -> REQ; latch cpu_vector=candidate, cpu_irq=1.
- FSM REQ: cpu_irq held, cpu_vector frozen.
  - On cpu_ack: INSERVICE[vec]<=1, clear pending[vec] if edge mode, cpu_irq<=0 -> IDLE.
  - Without ack: if pending[vec]&MASK[vec] dropped -> cpu_irq<=0, -> IDLE (spurious withdrawal). A newly pending higher source does not replace the vector.
- cpu_ack in IDLE ignored.

## Timing
- Reset: MASK, MODE, PENDING, INSERVICE, irq_q = 0; cpu_irq=0, cpu_vector=0, state IDLE. Reset during REQ drops cpu_irq at that edge.
- Latency: irq_in rise sampled at edge E1 sets pending; cpu_irq=1 after E2. Two cycles irq_in-to-cpu_irq when masked in and nothing in service.
- After ack at edge Ea, cpu_irq=0 after Ea; a further candidate may raise it again after Ea+1 (minimum one low cycle).
- Register writes take effect at the edge they are sampled; read_result reflects them the following cycle.
- Simultaneous events, same edge:
  - Edge set and W1C on same bit: set wins.
  - Edge set and ack on same bit: pending stays 1, INSERVICE set.
  - EOI and ack: EOI uses pre-edge INSERVICE, then ack bit is set.
  - MASK write clearing vec during REQ and ack same edge: ack wins.
- Level source still asserted after ack and EOI re-requests on the next IDLE evaluation.

## Test plan
- Reset -> all reads at 0x7f20..0x7f34 return 0, cpu_irq=0; write MASK=0x3F, MODE=0x01, read back 0x3F / 0x01.
- MASK=0x01, MODE=0x01, pulse irq_in[0] one cycle -> PENDING=0x01, cpu_irq=1 two cycles later, cpu_vector=0; ack -> PENDING=0, INSERVICE=0x01, cpu_irq=0; EOI -> INSERVICE=0.
- MASK=0x06, level mode, irq_in=0x06 held -> vector 1; ack; vector 2 never raised while INSERVICE=0x02; EOI -> vector 2 requested (or 1 again while irq_in[1] high).
- Nesting: source 3 in service, irq_in[1] edge -> cpu_irq with vector 1; ack -> INSERVICE=0x0A; EOI clears bit 1 only (0x08).
- Withdrawal: REQ on vector 2 (edge), write W1C 0x04 before ack -> cpu_irq falls next edge, later cpu_ack ignored, INSERVICE stays 0.
- Same-edge W1C 0x01 with new rising irq_in[0] -> PENDING bit 0 remains 1; rst asserted during REQ -> cpu_irq=0, all registers 0.
